click_counter: RTL and testbench

//  Sits directly downstream of debouncer and consumes its 1-cycle key_pressed_stb_o pulses.

---
 rtl/click_counter.sv | 124 ++++++++++++
 tb/tb_click_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/click_counter.sv
// click_counter
//
// Groups single-cycle press strobes from the debouncer into bursts. A burst
// closes when no press has arrived for WINDOW_CYCLES clocks, or as soon as
// it reaches MAX_CLICKS presses. At close, the number of presses is reported
// with a one-cycle click_valid_o pulse. click_cnt_o holds that number until
// the next report.
//
// Timing: if the last press of a burst is sampled at edge t and there are no
// presses at edges t+1 .. t+W (W = WINDOW_CYCLES), the report is made at
// edge t+W. A press sampled at that same edge wins: it is counted and the
// window restarts.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no burst open; waiting for the first press
// COUNT | burst open; counting presses and timing the quiet window
//
// Parameter constraints: MAX_CLICKS >= 1, WINDOW_CYCLES >= 2.

module click_counter #(
    parameter int  CLK_FREQ_MHZ   = 100,
    parameter int  WINDOW_TIME_US = 250_000,
    parameter int  MAX_CLICKS     = 4,
    localparam int WINDOW_CYCLES  = CLK_FREQ_MHZ * WINDOW_TIME_US,
    localparam int CNT_W          = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_pressed_stb_i,
    output logic             busy_o,
    output logic             click_valid_o,
    output logic [CNT_W-1:0] click_cnt_o
);

    localparam int TIMER_W = $clog2(WINDOW_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   count;

    logic [CNT_W-1:0]   count_inc;
    logic               reach_max;
    logic               window_done;

    // Next count if the current strobe is taken, and the two burst-closing conditions.
    always_comb begin
        count_inc   = count + CNT_ONE;
        reach_max   = (count_inc == CNT_MAX);
        window_done = (timer == TIMER_LAST);
    end

    // Burst FSM with registered outputs; the count saturates at MAX_CLICKS by reporting there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            timer         <= '0;
            count         <= '0;
            busy_o        <= 1'b0;
            click_valid_o <= 1'b0;
            click_cnt_o   <= '0;
        end else begin
            click_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_pressed_stb_i) begin
                        if (MAX_CLICKS == 1) begin
                            // A single press already fills the burst: report without opening one.
                            click_valid_o <= 1'b1;
                            click_cnt_o   <= CNT_ONE;
                        end else begin
                            count  <= CNT_ONE;
                            timer  <= '0;
                            state  <= COUNT;
                            busy_o <= 1'b1;
                        end
                    end
                end

                COUNT: begin
                    if (key_pressed_stb_i) begin
                        if (reach_max) begin
                            click_valid_o <= 1'b1;
                            click_cnt_o   <= count_inc;
                            count         <= '0;
                            timer         <= '0;
                            state         <= IDLE;
                            busy_o        <= 1'b0;
                        end else begin
                            count <= count_inc;
                            timer <= '0;
                        end
                    end else if (window_done) begin
                        click_valid_o <= 1'b1;
                        click_cnt_o   <= count;
                        count         <= '0;
                        timer         <= '0;
                        state         <= IDLE;
                        busy_o        <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                default: begin
                    count  <= '0;
                    timer  <= '0;
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_click_counter.sv
// tb_click_counter
//
// Drives press strobes (directed bursts, then random gaps) into click_counter.
// A reference model tracks each burst by absolute edge numbers: press count
// and the edge of the last press. Every expected report (edge, count) goes
// into a queue; a monitor pops it when click_valid_o is seen and also checks
// busy_o and the held click_cnt_o every cycle.

module tb_click_counter;

    localparam int CLK_MHZ = 100;
    localparam int WIN_US  = 1;
    localparam int MAXC    = 4;
    localparam int W       = CLK_MHZ * WIN_US;
    localparam int CW      = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          busy;
    logic          valid;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int e;
        int c;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, always reflecting edges up to and including cyc.
    bit m_active = 0;
    int m_count  = 0;
    int m_last   = 0;
    int m_out    = 0;

    click_counter #(
        .CLK_FREQ_MHZ  (CLK_MHZ),
        .WINDOW_TIME_US(WIN_US),
        .MAX_CLICKS    (MAXC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .key_pressed_stb_i(stb),
        .busy_o           (busy),
        .click_valid_o    (valid),
        .click_cnt_o      (cnt)
    );

    always #5 clk = ~clk;

    // Edge counter: cyc is the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Apply one rising edge e (with strobe s) to the model.
    task automatic model_edge(input int e, input bit s);
        bit report;
        report = 0;
        if (m_active && !s && (e == m_last + W)) begin
            report = 1;
        end else if (s) begin
            if (!m_active) begin
                m_active = 1;
                m_count  = 1;
            end else begin
                m_count++;
            end
            m_last = e;
            if (m_count == MAXC) report = 1;
        end
        if (report) begin
            exp_q.push_back('{e: e, c: m_count});
            m_out    = m_count;
            m_active = 0;
            m_count  = 0;
        end
    endtask

    // Drive the strobe for the next rising edge.
    task automatic step(input bit s);
        @(negedge clk);
        #1;
        stb = s;
        model_edge(cyc + 1, s);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        stb = 1'b0;
        m_active = 0;
        m_count  = 0;
        m_out    = 0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_cnt", int'(cnt), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].e < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_report: expected cnt %0d at edge %0d, no pulse by edge %0d",
                         exp_q[0].c, exp_q[0].e, cyc);
                void'(exp_q.pop_front());
            end
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_report at edge %0d: got cnt %0d, expected no report",
                             cyc, cnt);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("report_edge", cyc, x.e);
                    check("report_cnt", int'(cnt), x.c);
                end
            end
            check("busy", int'(busy), int'(m_active));
            check("held_cnt", int'(cnt), m_out);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int gaps[11];
        gaps = '{1, 2, 3, 10, 50, 98, 99, 100, 101, 102, 150};

        // Reset state while reset is held.
        #12;
        check("por_busy", int'(busy), 0);
        check("por_valid", int'(valid), 0);
        check("por_cnt", int'(cnt), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        quiet(3);

        // Single press then quiet.
        step(1'b1);
        quiet(W + 20);

        // Presses 50 apart: one burst of three.
        step(1'b1); quiet(49);
        step(1'b1); quiet(49);
        step(1'b1); quiet(W + 20);

        // Second press exactly on the timeout edge.
        step(1'b1); quiet(W - 1);
        step(1'b1); quiet(W + 20);

        // Six presses 10 apart: saturates at MAX_CLICKS, then a burst of two.
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            quiet(9);
        end
        quiet(W + 20);

        // Reset in the middle of a burst discards it.
        step(1'b1); quiet(19);
        step(1'b1); quiet(8);
        pulse_reset();
        quiet(27);
        step(1'b1); quiet(W + 20);

        // Back-to-back presses, then check the count is held.
        step(1'b1); step(1'b1); step(1'b1);
        quiet(W + 50);

        // Random gaps, including gaps at and around the window length.
        for (int k = 0; k < 300; k++) begin
            int g;
            g = gaps[$urandom_range(0, 10)];
            quiet(g - 1);
            step(1'b1);
            if ($urandom_range(0, 60) == 0) begin
                quiet($urandom_range(0, 40));
                pulse_reset();
            end
        end
        step(1'b0);
        quiet(W + 20);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
